// File: rtl/telephony_pkg.sv
// Shared definitions for the telephony transport path: command codes,
// TX framing FSM states and header field widths.
package telephony_pkg;

  localparam int CMD_W   = 2;
  localparam int PHONE_W = 8;
  localparam int DATA_W  = 16;
  localparam int SEQ_W   = 6;
  localparam int LEN_W   = 6;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_VOICE = 2'b01,
    CMD_CTRL  = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEST,
    ST_SEQ,
    ST_LEN,
    ST_PAY_HI,
    ST_PAY_LO,
    ST_CSUM
  } tx_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]   cmd;
    logic [PHONE_W-1:0] phone;
    logic [DATA_W-1:0]  data;
  } word_t;

  localparam int WORD_W = $bits(word_t);

endpackage

// File: rtl/tp_fifo.sv
// Show-ahead synchronous FIFO: rdata always presents the oldest entry.
// Push when full and pop when empty are ignored.
module tp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= inc(wp);
      if (pop_ok)  rp <= inc(rp);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/transport_tx.sv
// Packetises session words into DEST/SEQ/LEN/payload byte frames.
// Define CHECKSUM_EN to append a modulo-256 checksum byte to every packet.
module transport_tx
  import telephony_pkg::*;
#(
  parameter int PKT_WORDS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sess_valid,
  input  logic [PHONE_W-1:0] phoneNum,
  input  logic [CMD_W-1:0]   cmd,
  input  logic [DATA_W-1:0]  data,
  output logic               transportBusy,
  output logic [BYTE_W-1:0]  tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sof,
  output logic               tx_eof
);

  localparam logic [LEN_W-1:0] PKT_LEN = LEN_W'(PKT_WORDS);

  tx_state_e         state, nxt;
  word_t             wr_word, head;
  logic [LEN_W-1:0]  open_cnt, len_head, rem, close_len;
  logic [SEQ_W-1:0]  seq;
  logic              pay_full, pay_empty, len_full, len_empty;
  logic              accept, close, fire, pay_pop, len_pop;

  assign accept    = sess_valid & ~transportBusy;
  assign close_len = open_cnt + LEN_W'(1);
  assign close     = accept & ((close_len == PKT_LEN) | (cmd == CMD_FLUSH));
  assign wr_word   = '{cmd: cmd, phone: phoneNum, data: data};
  assign fire      = tx_valid & tx_ready;
  assign pay_pop   = fire & (state == ST_PAY_LO) & ~pay_empty;
  assign len_pop   = fire & (state == ST_LEN);

  assign transportBusy = pay_full | len_full;

  tp_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_pay (
    .clk(clk), .reset(reset), .push(accept), .wdata(wr_word),
    .pop(pay_pop), .rdata(head), .full(pay_full), .empty(pay_empty)
  );

  tp_fifo #(.W(LEN_W), .DEPTH(4)) u_len (
    .clk(clk), .reset(reset), .push(close), .wdata(close_len),
    .pop(len_pop), .rdata(len_head), .full(len_full), .empty(len_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      open_cnt <= '0;
      rem      <= '0;
      seq      <= '0;
    end else begin
      state <= nxt;
      if (accept) open_cnt <= close ? '0 : close_len;
      // rem counts payload words still to send, including the head word
      if (len_pop)               rem <= len_head;
      else if (pay_pop)          rem <= rem - LEN_W'(1);
      if (fire && tx_eof)        seq <= seq + SEQ_W'(1);
    end
  end

`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    csum <= '0;
    else if (fire) csum <= (state == ST_DEST) ? tx_byte : csum + tx_byte;
  end
`endif

  // Outputs decode from state and FIFO heads, which only move on acceptance,
  // so a stalled byte stays stable without extra holding registers.
  always_comb begin
    nxt      = state;
    tx_byte  = '0;
    tx_valid = 1'b1;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_valid = 1'b0;
        if (!len_empty) nxt = ST_DEST;
      end
      ST_DEST: begin
        tx_byte = head.phone;
        tx_sof  = 1'b1;
        if (fire) nxt = ST_SEQ;
      end
      ST_SEQ: begin
        tx_byte = {head.cmd, seq};
        if (fire) nxt = ST_LEN;
      end
      ST_LEN: begin
        tx_byte = {2'b00, len_head};
        if (fire) nxt = ST_PAY_HI;
      end
      ST_PAY_HI: begin
        tx_byte = head.data[15:8];
        if (fire) nxt = ST_PAY_LO;
      end
      ST_PAY_LO: begin
        tx_byte = head.data[7:0];
        if (rem != LEN_W'(1)) begin
          if (fire) nxt = ST_PAY_HI;
        end else begin
`ifdef CHECKSUM_EN
          if (fire) nxt = ST_CSUM;
`else
          tx_eof = 1'b1;
          if (fire) nxt = len_empty ? ST_IDLE : ST_DEST;
`endif
        end
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        tx_byte = csum;
        tx_eof  = 1'b1;
        if (fire) nxt = len_empty ? ST_IDLE : ST_DEST;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        nxt      = ST_IDLE;
      end
    endcase
  end

endmodule
